// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
// Optional watchdog: PKT_ARB_WDOG_EN.
package pkt_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_WDOG = 3'b100
  } state_e;

  localparam int PKT_ARB_DW = 8;
  localparam int PTR_W      = 3;

  // Explicit wrap so non-power-of-2 port counts rotate correctly
  function automatic logic [PTR_W-1:0] rr_inc(
    input logic [PTR_W-1:0] v,
    input logic [PTR_W-1:0] last
  );
    return (v == last) ? '0 : v + PTR_W'(1);
  endfunction

endpackage

// File: rtl/pkt_arb_rr_sel.sv
// Combinational round-robin pick: first request after ptr_i,
// wrapping, returned as one-hot grant and binary index.
module pkt_arb_rr_sel
  import pkt_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IW-1:0]        ptr_i,
  output logic                 any_o,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IW-1:0]        idx_o
);

  logic [IW-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    cand  = ptr_i;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = IW'(rr_inc(PTR_W'(cand),
                        PTR_W'(NUM_PORTS - 1)));
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS byte streams.
// Define PKT_ARB_WDOG_EN to terminate stalled packets after WDOG_CYC.
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DW        = PKT_ARB_DW,
  parameter int WDOG_CYC  = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS*DW-1:0] din,
  input  logic [NUM_PORTS-1:0]    din_vld,
  input  logic [NUM_PORTS-1:0]    din_sop,
  input  logic [NUM_PORTS-1:0]    din_eop,
  output logic [NUM_PORTS-1:0]    din_rdy,
  output logic [DW-1:0]           dout,
  output logic                    dout_vld,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic [NUM_PORTS-1:0]    grant,
  output logic                    err_proto,
  output logic                    wdog_err
);

  localparam int IW = $clog2(NUM_PORTS);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 first_q, first_d;
  logic [DW-1:0]        dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic                 err_q, err_d;
  logic                 wdog_q, wdog_d;
  logic [NUM_PORTS-1:0] rdy_c;

  logic [NUM_PORTS-1:0] req, stray;
  logic                 any;
  logic [NUM_PORTS-1:0] sel_gnt;
  logic [IW-1:0]        sel_idx;

  logic [DW-1:0]        sel_d;
  logic                 sel_vld, sel_sop, sel_eop;

  assign req   = din_vld & din_sop;
  assign stray = din_vld & ~din_sop;

  pkt_arb_rr_sel #(
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_sel (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (any),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx)
  );

  // One-hot AND-OR mux of the granted port
  always_comb begin
    sel_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) sel_d = sel_d | din[p*DW +: DW];
    end
  end

  assign sel_vld = |(din_vld & grant_q);
  assign sel_sop = |(din_sop & grant_q);
  assign sel_eop = |(din_eop & grant_q);

`ifdef PKT_ARB_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYC);
  localparam logic [WCW-1:0] WC_LAST = WCW'(WDOG_CYC - 1);

  logic [WCW-1:0] wcnt_q, wcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    rdy_c   = '0;
    dout_d  = '0;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    wdog_d  = 1'b0;
`ifdef PKT_ARB_WDOG_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        rdy_c = stray;
        err_d = |stray;
        if (any) begin
          state_d = ST_BUSY;
          grant_d = sel_gnt;
          idx_d   = sel_idx;
          first_d = 1'b1;
`ifdef PKT_ARB_WDOG_EN
          wcnt_d  = '0;
`endif
        end
      end
      ST_BUSY: begin
        rdy_c = grant_q;
        if (sel_vld) begin
          dout_d  = sel_d;
          vld_d   = 1'b1;
          sop_d   = sel_sop & first_q;
          eop_d   = sel_eop;
          err_d   = sel_sop & ~first_q;
          first_d = 1'b0;
`ifdef PKT_ARB_WDOG_EN
          wcnt_d  = '0;
`endif
          if (sel_eop) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = idx_q;
          end
        end
`ifdef PKT_ARB_WDOG_EN
        else if (wcnt_q == WC_LAST) begin
          state_d = ST_WDOG;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
`endif
      end
`ifdef PKT_ARB_WDOG_EN
      ST_WDOG: begin
        vld_d   = 1'b1;
        eop_d   = 1'b1;
        wdog_d  = 1'b1;
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = idx_q;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(NUM_PORTS - 1);
      first_q <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

`ifdef PKT_ARB_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end
  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

  // Ready is held low while reset is asserted
  assign din_rdy   = rdy_c & {NUM_PORTS{rst_n}};
  assign dout      = dout_q;
  assign dout_vld  = vld_q;
  assign dout_sop  = sop_q;
  assign dout_eop  = eop_q;
  assign grant     = grant_q;
  assign err_proto = err_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter (4 ports, 8-bit data).
// Watchdog case runs only with PKT_ARB_WDOG_EN, WDOG_CYC=16.
module tb_pkt_rr_arbiter;

  typedef struct packed {
    logic       bub;
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } ent_t;

  typedef struct {
    logic [9:0] v;
    int         cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic [3:0]  din_vld = '0;
  logic [3:0]  din_sop = '0;
  logic [3:0]  din_eop = '0;
  logic [3:0]  din_rdy;
  logic [7:0]  dout;
  logic        dout_vld, dout_sop, dout_eop;
  logic [3:0]  grant;
  logic        err_proto, wdog_err;

  ent_t        srcq[4][$];
  obs_t        out_q[$];
  logic [9:0]  exp_q[$];
  logic [3:0]  rdy_s;
  int          cyc, n_err, n_wdog;
  int          n_chk, n_fail;

  pkt_rr_arbiter #(
    .NUM_PORTS (4),
    .DW        (8),
    .WDOG_CYC  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .din_sop   (din_sop),
    .din_eop   (din_eop),
    .din_rdy   (din_rdy),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_sop  (dout_sop),
    .dout_eop  (dout_eop),
    .grant     (grant),
    .err_proto (err_proto),
    .wdog_err  (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [31:0] dv;
    logic [3:0]  v, s, e;
    dv = '0; v = '0; s = '0; e = '0;
    for (int p = 0; p < 4; p++) begin
      if (srcq[p].size() > 0 && !srcq[p][0].bub) begin
        v[p] = 1'b1;
        s[p] = srcq[p][0].sop;
        e[p] = srcq[p][0].eop;
        dv[p*8 +: 8] = srcq[p][0].d;
      end
    end
    din = dv; din_vld = v; din_sop = s; din_eop = e;
  endtask

  task automatic step();
    logic [3:0] acc;
    obs_t o;
    @(negedge clk);
    rdy_s = din_rdy;
    acc   = din_vld & din_rdy;
    if (dout_vld) begin
      o.v = {dout_sop, dout_eop, dout};
      o.cyc = cyc;
      out_q.push_back(o);
    end
    if (err_proto) n_err++;
    if (wdog_err) n_wdog++;
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 4; p++) begin
      if (srcq[p].size() > 0 &&
          (srcq[p][0].bub || acc[p]))
        void'(srcq[p].pop_front());
    end
    drive();
  endtask

  function automatic bit all_empty();
    return srcq[0].size() == 0 && srcq[1].size() == 0 &&
           srcq[2].size() == 0 && srcq[3].size() == 0;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!all_empty() && n < 2000) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 2000), 32'd1);
    repeat (3) step();
  endtask

  task automatic push_raw(input int p, input logic b,
                          input logic s, input logic e,
                          input logic [7:0] d);
    ent_t x;
    x.bub = b; x.sop = s; x.eop = e; x.d = d;
    srcq[p].push_back(x);
  endtask

  task automatic push_pkt(input int p, input int n,
                          input logic [7:0] base);
    for (int i = 0; i < n; i++)
      push_raw(p, 1'b0, i == 0, i == n - 1, 8'(base + i));
  endtask

  task automatic exp_pkt(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++)
      exp_q.push_back({i == 0, i == n - 1, 8'(base + i)});
  endtask

  task automatic cmp_out(input string tag);
    chk({tag, "_n"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_q.size())
        chk($sformatf("%s_b%0d", tag, i),
            32'(out_q[i].v), 32'(exp_q[i]));
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < 4; p++) srcq[p].delete();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_q.delete();
    exp_q.delete();
    n_err = 0;
    n_wdog = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    n_err = 0; n_wdog = 0; rdy_s = '0;
    #1;
    chk("rst_vld", 32'(dout_vld), 32'd0);
    chk("rst_gnt", 32'(grant), 32'd0);
    chk("rst_rdy", 32'(din_rdy), 32'd0);
    do_reset();

    // single 5-byte packet on port 1
    push_pkt(1, 5, 8'h10);
    drive();
    step();
    chk("t1_gnt", 32'(grant), 32'h2);
    drain("t1");
    exp_pkt(5, 8'h10);
    cmp_out("t1");
    chk("t1_idle_gnt", 32'(grant), 32'h0);
    chk("t1_err", n_err, 0);

    // tie between 0,2,3 then all four
    do_reset();
    push_pkt(0, 3, 8'h20);
    push_pkt(2, 3, 8'h28);
    push_pkt(3, 3, 8'h2c);
    drive();
    drain("t2a");
    if (out_q.size() > 3)
      chk("t2_gap", out_q[3].cyc - out_q[2].cyc, 2);
    exp_pkt(3, 8'h20);
    exp_pkt(3, 8'h28);
    exp_pkt(3, 8'h2c);
    cmp_out("t2a");
    for (int p = 0; p < 4; p++)
      push_pkt(p, 3, 8'(8'h30 + p * 4));
    drive();
    drain("t2b");
    for (int p = 0; p < 4; p++)
      exp_pkt(3, 8'(8'h30 + p * 4));
    cmp_out("t2b");

    // stray byte in IDLE
    do_reset();
    push_raw(2, 1'b0, 1'b0, 1'b0, 8'hAA);
    drive();
    step();
    chk("t3_rdy", 32'(rdy_s), 32'h4);
    drain("t3");
    cmp_out("t3");
    chk("t3_err", n_err, 1);

    // 10-cycle stall mid-packet
    do_reset();
    push_raw(0, 1'b0, 1'b1, 1'b0, 8'h40);
    push_raw(0, 1'b0, 1'b0, 1'b0, 8'h41);
    repeat (10) push_raw(0, 1'b1, 1'b0, 1'b0, 8'h00);
    push_raw(0, 1'b0, 1'b0, 1'b0, 8'h42);
    push_raw(0, 1'b0, 1'b0, 1'b1, 8'h43);
    drive();
    drain("t4");
    if (out_q.size() > 2)
      chk("t4_gap", out_q[2].cyc - out_q[1].cyc, 11);
    exp_pkt(4, 8'h40);
    cmp_out("t4");
    chk("t4_err", n_err, 0);

    // sop repeated inside a packet
    do_reset();
    push_raw(1, 1'b0, 1'b1, 1'b0, 8'h70);
    push_raw(1, 1'b0, 1'b1, 1'b0, 8'h71);
    push_raw(1, 1'b0, 1'b0, 1'b1, 8'h72);
    drive();
    drain("t7");
    exp_pkt(3, 8'h70);
    cmp_out("t7");
    chk("t7_err", n_err, 1);

`ifdef PKT_ARB_WDOG_EN
    // watchdog on port 3, late tail flushed
    do_reset();
    push_raw(3, 1'b0, 1'b1, 1'b0, 8'h80);
    push_raw(3, 1'b0, 1'b0, 1'b0, 8'h81);
    repeat (20) push_raw(3, 1'b1, 1'b0, 1'b0, 8'h00);
    push_raw(3, 1'b0, 1'b0, 1'b0, 8'h82);
    push_raw(3, 1'b0, 1'b0, 1'b1, 8'h83);
    drive();
    drain("t5");
    if (out_q.size() > 2)
      chk("t5_gap", out_q[2].cyc - out_q[1].cyc, 17);
    exp_q.push_back({2'b10, 8'h80});
    exp_q.push_back({2'b00, 8'h81});
    exp_q.push_back({2'b01, 8'h00});
    cmp_out("t5");
    chk("t5_wdog", n_wdog, 1);
    chk("t5_err", n_err, 2);
`else
    // long stall never terminates the packet
    do_reset();
    push_raw(3, 1'b0, 1'b1, 1'b0, 8'h80);
    repeat (40) push_raw(3, 1'b1, 1'b0, 1'b0, 8'h00);
    push_raw(3, 1'b0, 1'b0, 1'b1, 8'h81);
    drive();
    drain("t5");
    exp_pkt(2, 8'h80);
    cmp_out("t5");
    chk("t5_wdog", n_wdog, 0);
`endif

    // reset mid-packet on port 1
    do_reset();
    push_pkt(1, 5, 8'h60);
    drive();
    repeat (3) step();
    chk("t6_pre_vld", 32'(dout_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_dout", 32'(dout), 32'd0);
    chk("t6_vld", 32'(dout_vld), 32'd0);
    chk("t6_sop_eop", 32'({dout_sop, dout_eop}), 32'd0);
    chk("t6_gnt", 32'(grant), 32'd0);
    chk("t6_flags", 32'({err_proto, wdog_err}), 32'd0);
    for (int p = 0; p < 4; p++) srcq[p].delete();
    din_vld = 4'b0100;
    din_sop = '0;
    din_eop = '0;
    #1;
    chk("t6_rdy", 32'(din_rdy), 32'd0);
    din_vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_q.delete();
    n_err = 0;
    push_pkt(1, 2, 8'h68);
    push_pkt(0, 2, 8'h64);
    drive();
    drain("t6");
    exp_pkt(2, 8'h64);
    exp_pkt(2, 8'h68);
    cmp_out("t6");
    chk("t6_err", n_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_fail);
    $finish;
  end

endmodule
